// File: rtl/score4_move_sequencer.sv
// Replays a stored script of left/right/put moves into the score4 button inputs,
// holding each button for a fixed number of clocks and pacing moves by VGA frames.
module score4_move_sequencer #(
   parameter int unsigned DEPTH           = 64,
   parameter int unsigned AW              = $clog2(DEPTH),
   parameter int unsigned HOLD_CYCLES     = 10,
   parameter int unsigned FRAMES_PER_MOVE = 1,
   parameter bit          VSYNC_ACT_LOW   = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [1:0]    wr_data,
   input  logic [AW:0]   length,
   input  logic          loop_en,
   input  logic          start,
   input  logic          stop,
   input  logic          vsync,
   output logic          left,
   output logic          right,
   output logic          put,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] move_idx,
   output logic [15:0]   move_cnt
);

   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned FW = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_MOVE - 1);
   localparam logic [AW:0]   DEPTH_W    = (AW + 1)'(DEPTH);

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_LEFT  = 2'b01;
   localparam logic [1:0] OP_RIGHT = 2'b10;
   localparam logic [1:0] OP_PUT   = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StHold,
      StWaitFrame,
      StDone
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [FW-1:0]   frame_q, frame_d;
   logic            vsync_q;
   logic [1:0]      rd_q;
   logic [1:0]      mem [DEPTH];

   logic [AW:0]     len_clamped;
   logic [AW:0]     idx_inc;
   logic            frame_start;

   assign len_clamped = (length > DEPTH_W) ? DEPTH_W : length;
   assign idx_inc     = {1'b0, idx_q} + {{AW{1'b0}}, 1'b1};
   assign frame_start = VSYNC_ACT_LOW ? (vsync_q & ~vsync) : (~vsync_q & vsync);

   // The edge register also loads during reset so leaving reset never fakes an edge.
   always_ff @(posedge clk) begin
      vsync_q <= vsync;
   end

   // Script RAM: not reset; writes are locked out while a script is playing.
   always_ff @(posedge clk) begin
      if (wr_en && !busy) begin
         mem[wr_addr] <= wr_data;
      end
      if (state_q == StFetch) begin
         rd_q <= mem[idx_q];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         frame_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         frame_q <= frame_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      frame_d = frame_q;
      if (stop) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  if (len_clamped != '0) begin
                     idx_d   = '0;
                     cnt_d   = '0;
                     state_d = StFetch;
                  end else begin
                     state_d = StDone;
                  end
               end
            end
            StFetch: begin
               state_d = StHold;
               hold_d  = '0;
               if (cnt_q != 16'hFFFF) begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            StHold: begin
               if (hold_q == HOLD_LAST) begin
                  state_d = StWaitFrame;
                  frame_d = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            StWaitFrame: begin
               if (frame_start) begin
                  if (frame_q == FRAME_LAST) begin
                     // length is re-read here so changes during playback apply now.
                     if (idx_inc < len_clamped) begin
                        idx_d   = idx_inc[AW-1:0];
                        state_d = StFetch;
                     end else if (loop_en) begin
                        idx_d   = '0;
                        state_d = StFetch;
                     end else begin
                        state_d = StDone;
                     end
                  end else begin
                     frame_d = frame_q + 1'b1;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      left  = 1'b0;
      right = 1'b0;
      put   = 1'b0;
      if (state_q == StHold) begin
         case (rd_q)
            OP_LEFT:  left  = 1'b1;
            OP_RIGHT: right = 1'b1;
            OP_PUT:   put   = 1'b1;
            OP_NOP:   ;
            default:  ;
         endcase
      end
   end

   assign busy     = (state_q == StFetch) || (state_q == StHold) || (state_q == StWaitFrame);
   assign done     = (state_q == StDone);
   assign move_idx = idx_q;
   assign move_cnt = cnt_q;

endmodule

// File: tb/tb_score4_move_sequencer.sv
// Scoreboard bench: expected button pulses are queued as moves are scripted and
// compared by a negedge monitor as the sequencer emits them.
module tb_score4_move_sequencer;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;
   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_LEFT  = 2'b01;
   localparam logic [1:0] OP_RIGHT = 2'b10;
   localparam logic [1:0] OP_PUT   = 2'b11;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [1:0]    wr_data = '0;
   logic [AW:0]   length = '0;
   logic          loop_en = 1'b0;
   logic          start = 1'b0;
   logic          start2 = 1'b0;
   logic          stop = 1'b0;
   logic          vsync = 1'b1;

   logic          left, right, put, busy, done;
   logic [AW-1:0] move_idx;
   logic [15:0]   move_cnt;
   logic          left2, right2, put2, busy2, done2;
   logic [AW-1:0] move_idx2;
   logic [15:0]   move_cnt2;

   always #5 clk = ~clk;

   score4_move_sequencer #(
      .DEPTH(DEPTH), .AW(AW), .HOLD_CYCLES(10), .FRAMES_PER_MOVE(1), .VSYNC_ACT_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .length(length), .loop_en(loop_en), .start(start), .stop(stop), .vsync(vsync),
      .left(left), .right(right), .put(put), .busy(busy), .done(done),
      .move_idx(move_idx), .move_cnt(move_cnt)
   );

   score4_move_sequencer #(
      .DEPTH(DEPTH), .AW(AW), .HOLD_CYCLES(3), .FRAMES_PER_MOVE(2), .VSYNC_ACT_LOW(1'b1)
   ) dut2 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .length(length), .loop_en(loop_en), .start(start2), .stop(stop), .vsync(vsync),
      .left(left2), .right(right2), .put(put2), .busy(busy2), .done(done2),
      .move_idx(move_idx2), .move_cnt(move_cnt2)
   );

   typedef struct {
      logic [1:0]    op;
      logic [AW-1:0] idx;
      int            len;
   } exp_t;

   exp_t       exp_q[$];
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         starts = 0;
   int         ends = 0;
   int         put_pulses = 0;
   int         last_start_cyc = 0;
   int         fall_cyc = 0;
   logic [2:0] prev_btn = 3'b000;
   logic [2:0] mon_btn;
   logic [1:0] cur_op = OP_NOP;
   logic [AW-1:0] cur_idx = '0;
   int         plen = 0;
   logic       bad = 1'b0;
   exp_t       mon_e;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic logic [1:0] btn_op(input logic [2:0] b);
      case (b)
         3'b001:  return OP_LEFT;
         3'b010:  return OP_RIGHT;
         3'b100:  return OP_PUT;
         default: return OP_NOP;
      endcase
   endfunction

   // Pulse monitor for the main instance: one scoreboard pop per completed pulse.
   initial forever begin
      @(negedge clk);
      mon_btn = {put, right, left};
      if (mon_btn != 3'b000) begin
         if (prev_btn == 3'b000) begin
            cur_op         = btn_op(mon_btn);
            cur_idx        = move_idx;
            plen           = 1;
            bad            = (cur_op == OP_NOP);
            last_start_cyc = cyc;
            starts++;
         end else begin
            plen++;
            if (mon_btn != prev_btn) bad = 1'b1;
         end
      end else if (prev_btn != 3'b000) begin
         ends++;
         if (cur_op == OP_PUT) put_pulses++;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL pulse_unexpected: got op=%0d idx=%0d len=%0d, expected no pulse",
                     cur_op, cur_idx, plen);
         end else begin
            mon_e = exp_q.pop_front();
            if (bad || cur_op !== mon_e.op || cur_idx !== mon_e.idx || plen != mon_e.len) begin
               fails++;
               $display("FAIL pulse_%0d: got op=%0d idx=%0d len=%0d clean=%0d, expected op=%0d idx=%0d len=%0d",
                        ends, cur_op, cur_idx, plen, !bad, mon_e.op, mon_e.idx, mon_e.len);
            end
         end
      end
      prev_btn = mon_btn;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   task automatic push_exp(input logic [1:0] op, input int idx, input int len);
      exp_t e;
      e.op  = op;
      e.idx = AW'(idx);
      e.len = len;
      exp_q.push_back(e);
   endtask

   task automatic write_op(input int a, input logic [1:0] op);
      @(posedge clk);
      #1 wr_en = 1'b1; wr_addr = AW'(a); wr_data = op;
      @(posedge clk);
      #1 wr_en = 1'b0;
   endtask

   task automatic pulse_start(output int c0);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      c0 = cyc;
   endtask

   task automatic frame_edge();
      @(posedge clk);
      #1 vsync = 1'b0;
      fall_cyc = cyc;
      repeat (3) @(posedge clk);
      #1 vsync = 1'b1;
   endtask

   task automatic wait_ends(input int n);
      int t = 0;
      while (ends < n && t < 300) begin
         @(posedge clk);
         t++;
      end
      if (ends < n) begin
         tests++; fails++;
         $display("FAIL timeout_pulse_end: got %0d pulses, expected %0d", ends, n);
      end
   endtask

   task automatic wait_starts(input int n);
      int t = 0;
      while (starts < n && t < 300) begin
         @(posedge clk);
         t++;
      end
      if (starts < n) begin
         tests++; fails++;
         $display("FAIL timeout_pulse_start: got %0d pulses, expected %0d", starts, n);
      end
   endtask

   task automatic test_reset();
      int c0, s0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++; if ({left, right, put} !== 3'b000) begin fails++; $display("FAIL reset_buttons: got %b expected 000", {left, right, put}); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
      tests++; if (move_idx !== '0) begin fails++; $display("FAIL reset_move_idx: got %0d expected 0", move_idx); end
      tests++; if (move_cnt !== 16'd0) begin fails++; $display("FAIL reset_move_cnt: got %0d expected 0", move_cnt); end
      rst = 1'b1;
      length = '0;
      s0 = starts;
      pulse_start(c0);
      tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL len0_done: got done=%b busy=%b expected done=1 busy=0", done, busy); end
      repeat (5) @(posedge clk);
      #1;
      tests++; if (starts != s0 || done !== 1'b1) begin fails++; $display("FAIL len0_quiet: got pulses=%0d done=%b expected pulses=%0d done=1", starts - s0, done, 0); end
   endtask

   task automatic test_script();
      int c0, base;
      write_op(0, OP_PUT);
      write_op(1, OP_RIGHT);
      write_op(2, OP_PUT);
      length = 7'd3; loop_en = 1'b0;
      push_exp(OP_PUT, 0, 10);
      push_exp(OP_RIGHT, 1, 10);
      push_exp(OP_PUT, 2, 10);
      base = ends;
      pulse_start(c0);
      tests++; if (done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL start_clears_done: got done=%b busy=%b expected done=0 busy=1", done, busy); end
      wait_ends(base + 1);
      tests++; if (last_start_cyc != c0 + 1) begin fails++; $display("FAIL first_latency: got cycle %0d expected %0d", last_start_cyc, c0 + 1); end
      frame_edge();
      wait_ends(base + 2);
      tests++; if (last_start_cyc != fall_cyc + 2) begin fails++; $display("FAIL move2_latency: got cycle %0d expected %0d", last_start_cyc, fall_cyc + 2); end
      frame_edge();
      wait_ends(base + 3);
      tests++; if (last_start_cyc != fall_cyc + 2) begin fails++; $display("FAIL move3_latency: got cycle %0d expected %0d", last_start_cyc, fall_cyc + 2); end
      @(posedge clk);
      #1 vsync = 1'b0;
      tests++; if (done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL wait_before_edge: got done=%b busy=%b expected done=0 busy=1", done, busy); end
      @(posedge clk);
      #1;
      tests++; if (done !== 1'b1 || busy !== 1'b0 || move_cnt !== 16'd3) begin fails++; $display("FAIL script_done: got done=%b busy=%b cnt=%0d expected done=1 busy=0 cnt=3", done, busy, move_cnt); end
      repeat (2) @(posedge clk);
      #1 vsync = 1'b1;
   endtask

   task automatic test_frames2();
      int hc;
      length = 7'd1;
      write_op(0, OP_LEFT);
      @(posedge clk);
      #1 start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      tests++; if (left2 !== 1'b0 || busy2 !== 1'b1) begin fails++; $display("FAIL fpm2_fetch: got left=%b busy=%b expected left=0 busy=1", left2, busy2); end
      hc = 0;
      repeat (3) begin
         @(posedge clk);
         #1 if (left2 === 1'b1) hc++;
      end
      vsync = 1'b0;  // falls during the last hold cycle: must not be counted
      tests++; if (hc != 3) begin fails++; $display("FAIL fpm2_hold: got %0d cycles expected 3", hc); end
      @(posedge clk);
      #1;
      tests++; if (left2 !== 1'b0) begin fails++; $display("FAIL fpm2_release: got %b expected 0", left2); end
      repeat (2) @(posedge clk);
      #1 vsync = 1'b1;
      repeat (2) @(posedge clk);
      #1 vsync = 1'b0;
      @(posedge clk);
      #1;
      tests++; if (done2 !== 1'b0 || busy2 !== 1'b1) begin fails++; $display("FAIL fpm2_edge1: got done=%b busy=%b expected done=0 busy=1", done2, busy2); end
      repeat (2) @(posedge clk);
      #1 vsync = 1'b1;
      repeat (2) @(posedge clk);
      #1 vsync = 1'b0;
      @(posedge clk);
      #1;
      tests++; if (done2 !== 1'b1 || busy2 !== 1'b0 || move_cnt2 !== 16'd1) begin fails++; $display("FAIL fpm2_edge2: got done=%b busy=%b cnt=%0d expected done=1 busy=0 cnt=1", done2, busy2, move_cnt2); end
      repeat (2) @(posedge clk);
      #1 vsync = 1'b1;
   endtask

   task automatic test_loop_stop();
      int c0, base, sb;
      write_op(0, OP_RIGHT);
      write_op(1, OP_LEFT);
      length = 7'd2; loop_en = 1'b1;
      push_exp(OP_RIGHT, 0, 10);
      push_exp(OP_LEFT, 1, 10);
      push_exp(OP_RIGHT, 0, 10);
      push_exp(OP_LEFT, 1, 10);
      push_exp(OP_RIGHT, 0, 5);
      base = ends;
      sb = starts;
      pulse_start(c0);
      for (int i = 0; i < 4; i++) begin
         wait_ends(base + i + 1);
         frame_edge();
      end
      wait_starts(sb + 5);
      repeat (3) @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      tests++; if (right !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL stop_idle: got right=%b busy=%b done=%b expected 0 0 0", right, busy, done); end
      tests++; if (move_cnt !== 16'd5) begin fails++; $display("FAIL loop_count: got %0d expected 5", move_cnt); end
      loop_en = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_busy_write();
      int c0, base;
      write_op(0, OP_LEFT);
      write_op(1, OP_RIGHT);
      length = 7'd2; loop_en = 1'b0;
      push_exp(OP_LEFT, 0, 10);
      push_exp(OP_RIGHT, 1, 10);
      base = ends;
      pulse_start(c0);
      @(posedge clk);
      #1 wr_en = 1'b1; wr_addr = '0; wr_data = OP_PUT; start = 1'b1;
      @(posedge clk);
      #1 wr_en = 1'b0; start = 1'b0;
      wait_ends(base + 1);
      frame_edge();
      wait_ends(base + 2);
      frame_edge();
      tests++; if (done !== 1'b1 || move_cnt !== 16'd2) begin fails++; $display("FAIL busy_run_done: got done=%b cnt=%0d expected done=1 cnt=2", done, move_cnt); end
      push_exp(OP_LEFT, 0, 10);
      push_exp(OP_RIGHT, 1, 10);
      pulse_start(c0);
      wait_ends(base + 3);
      frame_edge();
      wait_ends(base + 4);
      frame_edge();
      tests++; if (done !== 1'b1 || move_cnt !== 16'd2) begin fails++; $display("FAIL replay_done: got done=%b cnt=%0d expected done=1 cnt=2", done, move_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] diag [15];
      int c0, base, pb;
      diag = '{OP_PUT, OP_RIGHT, OP_PUT, OP_RIGHT, OP_PUT, OP_PUT, OP_RIGHT, OP_PUT,
               OP_PUT, OP_PUT, OP_RIGHT, OP_PUT, OP_PUT, OP_PUT, OP_PUT};
      for (int i = 0; i < 15; i++) begin
         write_op(i, diag[i]);
         push_exp(diag[i], i, 10);
      end
      length = 7'd15; loop_en = 1'b0;
      pb = put_pulses;
      base = ends;
      pulse_start(c0);
      for (int i = 0; i < 15; i++) begin
         wait_ends(base + i + 1);
         frame_edge();
      end
      tests++; if (done !== 1'b1 || move_cnt !== 16'd15) begin fails++; $display("FAIL diag_done: got done=%b cnt=%0d expected done=1 cnt=15", done, move_cnt); end
      tests++; if (put_pulses - pb != 11) begin fails++; $display("FAIL diag_puts: got %0d expected 11", put_pulses - pb); end
   endtask

   task automatic test_reset_mid();
      int c0;
      push_exp(OP_PUT, 0, 2);
      pulse_start(c0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      tests++; if (put !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || move_cnt !== 16'd0) begin fails++; $display("FAIL reset_mid: got put=%b busy=%b done=%b cnt=%0d expected 0 0 0 0", put, busy, done, move_cnt); end
      rst = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_script();
      test_frames2();
      test_loop_stop();
      test_busy_write();
      test_back_to_back();
      test_reset_mid();
      #1;
      tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
